// File: rtl/mpr_pkg.sv
// Shared types and helpers for the multi-port RAM with hardware clear.
// The conflict check works on zero-extended, fixed-size port vectors so one function serves every configuration.
package mpr_pkg;

  localparam int MAX_WR = 4;
  localparam int MAX_AW = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // True when two or more enabled write ports carry the same address.
  function automatic logic conflict_detect(
    input logic [MAX_WR-1:0]             we,
    input logic [MAX_WR-1:0][MAX_AW-1:0] addr
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_WR; i++) begin
      for (int k = i + 1; k < MAX_WR; k++) begin
        if (we[i] && we[k] && (addr[i] == addr[k])) begin
          hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/mpr_if.sv
// Write/read bus of the multi-port RAM; the client drives through master, the RAM sits on slave.
interface mpr_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 4,
  parameter int AW     = $clog2(DEPTH)
) ();

  logic                     clr_req;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     ready;
  logic                     wr_conflict;

  modport master (
    output clr_req, we, wr_addr, wr_data, rd_addr,
    input  rd_data, ready, wr_conflict
  );

  modport slave (
    input  clr_req, we, wr_addr, wr_data, rd_addr,
    output rd_data, ready, wr_conflict
  );

endinterface

// File: rtl/mpr_wr_arbiter.sv
// Per-read-port write bypass: reports whether any enabled write hits rd_addr and which data wins.
module mpr_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int NUM_WR = 2,
  parameter int AW     = 6
) (
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  // Ascending scan: a later (higher-index) match overrides, so the highest port wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && (wr_addr[i*AW +: AW] == rd_addr)) begin
        hit  = 1'b1;
        data = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/multi_port_ram_clr.sv
// Multi-port RAM with sequential hardware clear, highest-port-wins write arbitration,
// configurable read-during-write behaviour and a registered write-conflict flag.
module multi_port_ram_clr
  import mpr_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                NUM_WR    = 2,
  parameter int                NUM_RD    = 4,
  parameter int                WR_FIRST  = 1,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic clk,
  input  logic rst_n,
  mpr_if.slave bus
);

  localparam int AW = clog2(DEPTH);

  state_t                         state_reg, state_next;
  logic [AW:0]                    clr_ptr_reg, clr_ptr_next, clr_ptr_inc;
  logic                           conflict_reg;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_reg;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_word;
  logic [NUM_RD-1:0]              byp_hit;
  logic [NUM_RD-1:0][DATA_W-1:0]  byp_data;
  logic [MAX_WR-1:0]              we_ext;
  logic [MAX_WR-1:0][MAX_AW-1:0]  addr_ext;
  logic [DATA_W-1:0]              mem [DEPTH];

  generate
    for (genvar gi = 0; gi < MAX_WR; gi++) begin : g_ext
      if (gi < NUM_WR) begin : g_used
        assign we_ext[gi]   = bus.we[gi];
        assign addr_ext[gi] = MAX_AW'(bus.wr_addr[gi*AW +: AW]);
      end else begin : g_unused
        assign we_ext[gi]   = 1'b0;
        assign addr_ext[gi] = '0;
      end
    end
  endgenerate

  // The extra pointer bit flags the terminal count on the cycle that writes the last word.
  assign clr_ptr_inc = clr_ptr_reg + (AW+1)'(1);

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    case (state_reg)
      CLEAR: begin
        clr_ptr_next = clr_ptr_inc;
        if (clr_ptr_inc[AW]) begin
          state_next = READY;
        end
      end
      READY: begin
        if (bus.clr_req) begin
          state_next   = CLEAR;
          clr_ptr_next = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= CLEAR;
      clr_ptr_reg  <= '0;
      conflict_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
      if (state_reg == READY) begin
        conflict_reg <= conflict_detect(we_ext, addr_ext);
        rd_data_reg  <= rd_word;
      end else begin
        conflict_reg <= 1'b0;
        rd_data_reg  <= '0;
      end
    end
  end

  // Later non-blocking writes in the ascending loop take effect, giving highest-port-wins.
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      mem[clr_ptr_reg[AW-1:0]] <= CLR_VALUE;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (bus.we[i]) begin
          mem[bus.wr_addr[i*AW +: AW]] <= bus.wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      mpr_wr_arbiter #(
        .DATA_W (DATA_W),
        .NUM_WR (NUM_WR),
        .AW     (AW)
      ) u_arb (
        .we      (bus.we),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (bus.rd_addr[gi*AW +: AW]),
        .hit     (byp_hit[gi]),
        .data    (byp_data[gi])
      );

      assign rd_word[gi] = ((WR_FIRST != 0) && byp_hit[gi]) ? byp_data[gi]
                                                             : mem[bus.rd_addr[gi*AW +: AW]];
    end
  endgenerate

  assign bus.rd_data     = rd_data_reg;
  assign bus.ready       = (state_reg == READY);
  assign bus.wr_conflict = conflict_reg;

endmodule

// File: tb/tb_multi_port_ram_clr.sv
// Bench for multi_port_ram_clr: write-first and read-first builds share stimulus and are
// compared every cycle against an address-map reference model, plus directed vectors.
module tb_multi_port_ram_clr;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int NUM_WR = 2;
  localparam int NUM_RD = 4;
  localparam int AW     = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpr_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD)) bus_wf ();
  mpr_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD)) bus_rf ();

  assign bus_rf.clr_req = bus_wf.clr_req;
  assign bus_rf.we      = bus_wf.we;
  assign bus_rf.wr_addr = bus_wf.wr_addr;
  assign bus_rf.wr_data = bus_wf.wr_data;
  assign bus_rf.rd_addr = bus_wf.rd_addr;

  multi_port_ram_clr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
                       .WR_FIRST(1), .CLR_VALUE('0))
    dut_wf (.clk(clk), .rst_n(rst_n), .bus(bus_wf.slave));

  multi_port_ram_clr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
                       .WR_FIRST(0), .CLR_VALUE('0))
    dut_rf (.clk(clk), .rst_n(rst_n), .bus(bus_rf.slave));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain array, clear progress counter, per-cycle address map of winning writes.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_clear;
  int                m_cnt;
  logic [DATA_W-1:0] exp_wf [NUM_RD];
  logic [DATA_W-1:0] exp_rf [NUM_RD];
  bit                exp_conf;
  bit                exp_ready;

  typedef struct {
    logic [1:0]  we;
    logic [5:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [5:0]  ra  [4];
    logic [31:0] ewf [4];
    logic [31:0] erf [4];
    logic        conf;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkv(input logic [1:0] we, input int wa0, input logic [31:0] wd0,
                               input int wa1, input logic [31:0] wd1,
                               input int r0, input int r1, input int r2, input int r3,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [31:0] f0, input logic [31:0] f1,
                               input logic [31:0] f2, input logic [31:0] f3,
                               input logic conf);
    vec_t v;
    v.we = we; v.wa0 = 6'(wa0); v.wd0 = wd0; v.wa1 = 6'(wa1); v.wd1 = wd1;
    v.ra[0] = 6'(r0); v.ra[1] = 6'(r1); v.ra[2] = 6'(r2); v.ra[3] = 6'(r3);
    v.ewf[0] = w0; v.ewf[1] = w1; v.ewf[2] = w2; v.ewf[3] = w3;
    v.erf[0] = f0; v.erf[1] = f1; v.erf[2] = f2; v.erf[3] = f3;
    v.conf = conf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    bus_wf.clr_req = 1'b0;
    bus_wf.we      = '0;
    bus_wf.wr_addr = '0;
    bus_wf.wr_data = '0;
    bus_wf.rd_addr = '0;
  endtask

  task automatic set_rd(input int r0, input int r1, input int r2, input int r3);
    bus_wf.rd_addr = {6'(r3), 6'(r2), 6'(r1), 6'(r0)};
  endtask

  task automatic model_step();
    logic [DATA_W-1:0] pend [int];
    int                hits [int];
    int                a;
    if (m_clear) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_clear = 1'b0;
      for (int j = 0; j < NUM_RD; j++) begin
        exp_wf[j] = '0;
        exp_rf[j] = '0;
      end
      exp_conf = 1'b0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus_wf.we[p]) begin
          a = int'(bus_wf.wr_addr[p*AW +: AW]);
          pend[a] = bus_wf.wr_data[p*DATA_W +: DATA_W];
          hits[a] = hits.exists(a) ? hits[a] + 1 : 1;
        end
      end
      exp_conf = 1'b0;
      foreach (hits[k]) if (hits[k] > 1) exp_conf = 1'b1;
      for (int j = 0; j < NUM_RD; j++) begin
        a = int'(bus_wf.rd_addr[j*AW +: AW]);
        exp_rf[j] = m_mem[a];
        exp_wf[j] = pend.exists(a) ? pend[a] : m_mem[a];
      end
      foreach (pend[k]) m_mem[k] = pend[k];
      if (bus_wf.clr_req) begin
        m_clear = 1'b1;
        m_cnt   = 0;
      end
    end
    exp_ready = !m_clear;
  endtask

  task automatic step(input string tag, input bit verbose);
    model_step();
    @(posedge clk);
    #1;
    check({tag, " ready_wf"}, 64'(bus_wf.ready), 64'(exp_ready));
    check({tag, " ready_rf"}, 64'(bus_rf.ready), 64'(exp_ready));
    check({tag, " conflict_wf"}, 64'(bus_wf.wr_conflict), 64'(exp_conf));
    check({tag, " conflict_rf"}, 64'(bus_rf.wr_conflict), 64'(exp_conf));
    for (int j = 0; j < NUM_RD; j++) begin
      check($sformatf("%s rd_wf[%0d]", tag, j), 64'(bus_wf.rd_data[j*DATA_W +: DATA_W]), 64'(exp_wf[j]));
      check($sformatf("%s rd_rf[%0d]", tag, j), 64'(bus_rf.rd_data[j*DATA_W +: DATA_W]), 64'(exp_rf[j]));
    end
    if (verbose)
      $display("[TB] %s we=%b clr=%b ready=%b conf=%b rd_wf=%h rd_rf=%h", tag, bus_wf.we,
               bus_wf.clr_req, bus_wf.ready, bus_wf.wr_conflict, bus_wf.rd_data, bus_rf.rd_data);
  endtask

  task automatic do_reset(input int hold, input string tag);
    rst_n   = 1'b0;
    m_clear = 1'b1;
    m_cnt   = 0;
    #1;
    check({tag, " reset ready"}, 64'(bus_wf.ready), 64'd0);
    check({tag, " reset conflict"}, 64'(bus_wf.wr_conflict), 64'd0);
    check({tag, " reset rd_data"}, 64'(bus_wf.rd_data[63:0] | bus_wf.rd_data[127:64]), 64'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_window(input string tag);
    for (int c = 1; c <= DEPTH; c++) begin
      step($sformatf("%s clr%0d", tag, c), 1'b0);
      check($sformatf("%s ready@%0d", tag, c), 64'(bus_wf.ready), 64'(c == DEPTH));
    end
    $display("[TB] %s clear window done, ready=%b", tag, bus_wf.ready);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    idle_inputs();

    // Table: writes/reads per cycle with hand-derived next-cycle outputs (write-first, read-first).
    vecs[0] = mkv(2'b01, 10, 11, 0, 0,  10, 0, 21, 63,  11, 0, 0, 0,  0, 0, 0, 0,  1'b0);
    vecs[1] = mkv(2'b00, 0, 0, 0, 0,  10, 10, 10, 10,  11, 11, 11, 11,  11, 11, 11, 11,  1'b0);
    vecs[2] = mkv(2'b11, 0, 111, 22, 32'd2100100100,  0, 22, 10, 5,
                  111, 32'd2100100100, 11, 0,  0, 0, 11, 0,  1'b0);
    vecs[3] = mkv(2'b00, 0, 0, 0, 0,  0, 22, 0, 22,
                  111, 32'd2100100100, 111, 32'd2100100100,
                  111, 32'd2100100100, 111, 32'd2100100100,  1'b0);
    vecs[4] = mkv(2'b11, 5, 7, 5, 9,  5, 5, 3, 0,  9, 9, 0, 111,  0, 0, 0, 111,  1'b1);
    vecs[5] = mkv(2'b00, 0, 0, 0, 0,  5, 22, 10, 0,
                  9, 32'd2100100100, 11, 111,  9, 32'd2100100100, 11, 111,  1'b0);
    vecs[6] = mkv(2'b01, 3, 55, 0, 0,  3, 5, 3, 22,
                  55, 9, 55, 32'd2100100100,  0, 9, 0, 32'd2100100100,  1'b0);
    vecs[7] = mkv(2'b00, 0, 0, 0, 0,  3, 3, 3, 3,  55, 55, 55, 55,  55, 55, 55, 55,  1'b0);
    vecs[8] = mkv(2'b11, 63, 1, 63, 2,  63, 10, 0, 5,  2, 11, 111, 9,  0, 11, 111, 9,  1'b1);
    vecs[9] = mkv(2'b10, 0, 0, 40, 32'hDEADBEEF,  63, 40, 0, 0,
                  2, 32'hDEADBEEF, 111, 111,  2, 0, 111, 111,  1'b0);

    // T1: reset and initial clear
    do_reset(2, "T1");
    clear_window("T1");
    set_rd(0, 21, 42, 63);
    step("T1 read", 1'b1);
    for (int j = 0; j < NUM_RD; j++)
      check($sformatf("T1 rd[%0d]", j), 64'(bus_wf.rd_data[j*DATA_W +: DATA_W]), 64'd0);

    // T2..T5: table-driven vectors
    for (int i = 0; i < 10; i++) begin
      bus_wf.we      = vecs[i].we;
      bus_wf.wr_addr = {vecs[i].wa1, vecs[i].wa0};
      bus_wf.wr_data = {vecs[i].wd1, vecs[i].wd0};
      set_rd(int'(vecs[i].ra[0]), int'(vecs[i].ra[1]), int'(vecs[i].ra[2]), int'(vecs[i].ra[3]));
      step($sformatf("vec%0d", i), 1'b1);
      check($sformatf("vec%0d conflict", i), 64'(bus_wf.wr_conflict), 64'(vecs[i].conf));
      for (int j = 0; j < NUM_RD; j++) begin
        check($sformatf("vec%0d wf port%0d", i, j), 64'(bus_wf.rd_data[j*DATA_W +: DATA_W]),
              64'(vecs[i].ewf[j]));
        check($sformatf("vec%0d rf port%0d", i, j), 64'(bus_rf.rd_data[j*DATA_W +: DATA_W]),
              64'(vecs[i].erf[j]));
      end
    end

    // T6: clear request with a same-cycle write, ignored writes mid-clear, then reset mid-clear
    bus_wf.clr_req = 1'b1;
    bus_wf.we      = 2'b01;
    bus_wf.wr_addr = {6'd0, 6'd22};
    bus_wf.wr_data = {32'd0, 32'h1234};
    set_rd(22, 22, 22, 22);
    step("T6 clr_req", 1'b1);
    check("T6 ready drop", 64'(bus_wf.ready), 64'd0);
    check("T6 same-cycle rd_wf", 64'(bus_wf.rd_data[31:0]), 64'h1234);
    check("T6 same-cycle rd_rf", 64'(bus_rf.rd_data[31:0]), 64'd2100100100);
    bus_wf.clr_req = 1'b0;
    bus_wf.we      = 2'b11;
    bus_wf.wr_addr = {6'd22, 6'd22};
    bus_wf.wr_data = {32'hAAAA5555, 32'h5555AAAA};
    for (int c = 0; c < 10; c++) step($sformatf("T6 midclr%0d", c), 1'b1);
    check("T6 rd held 0", 64'(bus_wf.rd_data[31:0]), 64'd0);
    idle_inputs();
    do_reset(1, "T6");
    clear_window("T6");
    set_rd(22, 3, 5, 40);
    step("T6 read", 1'b1);
    check("T6 addr22 cleared", 64'(bus_wf.rd_data[31:0]), 64'd0);
    check("T6 addr40 cleared", 64'(bus_wf.rd_data[127:96]), 64'd0);

    // Random traffic on a narrow address range to force conflicts and bypass hits
    for (int n = 0; n < 400; n++) begin
      bus_wf.clr_req = ($urandom_range(0, 99) == 0);
      bus_wf.we      = 2'($urandom_range(0, 3));
      bus_wf.wr_addr = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      bus_wf.wr_data = {32'($urandom), 32'($urandom)};
      set_rd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step($sformatf("rnd%0d", n), 1'b1);
    end
    idle_inputs();
    step("final", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
